vga_pixel_buffer: RTL and testbench
===================================

# vga_pixel_buffer

Single-clock frame store between the camera colour classifier and the VGA monitor. It takes the classifier's 3-bit pixel stream with line and frame markers and decimates it 4:1 in each axis into a 160x120 on-chip buffer. A 640x480@60 VGA timing generator reads the buffer back, replicating each stored pixel into a 4x4 block. Output is 3-bit colour plus sync.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SHIFT, 2, decimation shift; buffer is (H_ACTIVE>>SHIFT) x (V_ACTIVE>>SHIFT) = 160x120 = 19200 words of 3 bits

Ports:
- clk_25  in  1  pixel clock. All inputs are synchronous to it.
- reset  in  1  synchronous, active-high reset
- pix_write  in  1  one-cycle strobe: pix_data is valid
- pix_data  in  3  colour {R,G,B}: 100 red, 010 green, 001 blue, 000 black, 111 white
- line_start  in  1  one-cycle pulse before the first pixel of each camera line
- frame_start  in  1  one-cycle pulse before the first line of each camera frame
- vga_rgb  out  3  colour to DAC; 000 while blanked
- vga_hsync  out  1  active-low horizontal sync
- vga_vsync  out  1  active-low vertical sync
- vga_blank  out  1  high outside the active area
- frame_done  out  1  one-cycle pulse when a complete camera frame has been stored
- overflow  out  1  sticky flag: a pixel fell outside the 640x480 capture window

## Operation
Write side:
- Counters: cam_x (10 bit), cam_y (9 bit), stored (15 bit), first_line flag.
- Priority, highest first: reset, frame_start, line_start, pix_write.
- frame_start:
  - cam_x=0, cam_y=0, first_line=1.
  - stored=0.
  - frame_done pulses next cycle if stored==19200 before clearing.
- line_start:
  - cam_x=0.
  - cam_y increments unless first_line; clear first_line.
- pix_write with cam_x<640 and cam_y<480:
  - If cam_x[1:0]==0 and cam_y[1:0]==0, write pix_data at address (cam_y>>2)*160+(cam_x>>2) and increment stored (saturating at 19200).
  - cam_x increments in every case.
- pix_write outside the window: no memory write, overflow<=1. overflow clears only on reset.
- A pixel in the same cycle as line_start or frame_start is processed after the marker. It is the pixel at x=0 of the new line or frame.
- Address arithmetic: (cam_y>>2)*160 is computed as (y<<7)+(y<<5), giving a 15-bit result. No general multiplier is used.

Read side:
- h_cnt runs 0..799 and wraps. v_cnt runs 0..524 and increments when h_cnt wraps.
- Active area: h_cnt<640 and v_cnt<480.
- Read address: (v_cnt>>2)*160+(h_cnt>>2), same shift-add form as the write side.
- hsync low for h_cnt in 656..751. vsync low for v_cnt in 490..491.
- Memory is simple dual-port with a synchronous read.
- A simultaneous read and write to the same address returns the old data (read-before-write).
- Memory contents are not reset.

## Timing
Reset values (in the cycle after reset is sampled high):
- vga_rgb=000, vga_hsync=1, vga_vsync=1, vga_blank=1.
- frame_done=0, overflow=0.
- All counters 0, first_line=0.

Reset deassertion:
- The first cycle with reset low has h_cnt=0, v_cnt=0.

Read pipeline, 2 cycles:
- Stage 1: address registered into the memory read.
- Stage 2: output registers.
- hsync, vsync and blank are delayed by the same 2 cycles, so all VGA outputs for counter value (h,v) appear together 2 cycles later.

Write latency:
- A pixel is written at the clock edge following the cycle in which pix_write is sampled.
- The read side sees it on the next read of that address.

frame_done:
- High exactly one cycle, in the cycle after frame_start.

Reset mid-frame:
- Reset aborts both sides immediately.
- The buffer keeps its contents. The write side waits for the next frame_start; pixels before it are counted as cam_y=0.

## Test plan
- Sync timing: run 2 full VGA frames with no writes. Required: period of 800x525 = 420000 cycles; hsync low 96 cycles starting 2 cycles after h_cnt=656; vsync low for 2 lines; blank high for 160 of every 800 cycles.
- Full frame store: frame_start, then 480 lines of line_start plus 640 pix_write carrying 100, then frame_start. Required: frame_done pulses once; during the next VGA frame every active vga_rgb=100.
- Decimation and replication: write pixel (x=4,y=8)=010 and all other pixels 001. Required: vga_rgb=010 exactly for h 4..7, v 8..11 (16 pixels); 001 elsewhere.
- Overflow: 641 pix_write in one line. Required: overflow=1 after the 641st write, memory unchanged by it; overflow stays set until reset.
- Simultaneous markers: frame_start and pix_write=111 in the same cycle. Required: address 0 holds 111. A truncated frame of 10 lines followed by frame_start gives frame_done=0.
- Reset mid-operation: assert reset at h_cnt=300, v_cnt=200. Required: next cycle all outputs at reset values; 2 cycles after deassertion, blank=0 and rgb equals buffer address 0.

Source files
------------

// File: rtl/vga_pixel_buffer.sv
// Camera-side 4:1 decimating frame store with a 640x480@60 VGA readout that
// replicates every stored pixel into a 4x4 block.
module vga_pixel_buffer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SHIFT    = 2
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       pix_write,
  input  logic [2:0] pix_data,
  input  logic       line_start,
  input  logic       frame_start,
  output logic [2:0] vga_rgb,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       vga_blank,
  output logic       frame_done,
  output logic       overflow
);
  localparam int unsigned LINE_W  = H_ACTIVE >> SHIFT;
  localparam int unsigned LINES   = V_ACTIVE >> SHIFT;
  localparam int unsigned DEPTH   = LINE_W * LINES;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned X_W     = $clog2(H_ACTIVE + 1);
  localparam int unsigned Y_W     = $clog2(V_ACTIVE + 1);
  localparam int unsigned ST_W    = $clog2(DEPTH + 1);
  localparam int unsigned A_W     = $clog2(DEPTH);
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);

  // Row base address as a constant-coefficient shift-add (160 -> (r<<7)+(r<<5)).
  function automatic logic [A_W-1:0] row_base(input logic [A_W-1:0] row);
    logic [A_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (((LINE_W >> i) & 32'd1) != 32'd0) acc = acc + (row << i);
    end
    return acc;
  endfunction

  logic [X_W-1:0]  r_cam_x;
  logic [Y_W-1:0]  r_cam_y;
  logic [ST_W-1:0] r_stored;
  logic            r_first_line;
  logic            r_wr_en;
  logic [A_W-1:0]  r_wr_addr;
  logic [2:0]      r_wr_data;

  logic [X_W-1:0]  w_x_eff;
  logic [Y_W-1:0]  w_y_eff;
  logic [ST_W-1:0] w_stored_eff;
  logic            w_first_eff;
  logic            w_in_win;
  logic            w_keep;
  logic [A_W-1:0]  w_wr_addr;

  // Markers take effect first so a same-cycle pixel lands at x=0 of the new line/frame.
  always_comb begin
    w_x_eff      = r_cam_x;
    w_y_eff      = r_cam_y;
    w_stored_eff = r_stored;
    w_first_eff  = r_first_line;
    if (frame_start) begin
      w_x_eff      = '0;
      w_y_eff      = '0;
      w_stored_eff = '0;
      w_first_eff  = 1'b1;
    end else if (line_start) begin
      w_x_eff     = '0;
      w_first_eff = 1'b0;
      if (!r_first_line) w_y_eff = r_cam_y + Y_W'(1);
    end
  end

  assign w_in_win  = (w_x_eff < X_W'(H_ACTIVE)) && (w_y_eff < Y_W'(V_ACTIVE));
  assign w_keep    = (w_x_eff[SHIFT-1:0] == '0) && (w_y_eff[SHIFT-1:0] == '0);
  assign w_wr_addr = row_base(A_W'(w_y_eff >> SHIFT)) + A_W'(w_x_eff >> SHIFT);

  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_cam_x      <= '0;
      r_cam_y      <= '0;
      r_stored     <= '0;
      r_first_line <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      r_cam_x      <= w_x_eff;
      r_cam_y      <= w_y_eff;
      r_stored     <= w_stored_eff;
      r_first_line <= w_first_eff;
      r_wr_en      <= 1'b0;
      frame_done   <= frame_start && (r_stored == ST_W'(DEPTH));
      if (pix_write) begin
        r_cam_x <= w_x_eff + X_W'(1);
        if (w_in_win) begin
          if (w_keep) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= pix_data;
            if (w_stored_eff != ST_W'(DEPTH)) r_stored <= w_stored_eff + ST_W'(1);
          end
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  logic [HC_W-1:0] r_h;
  logic [VC_W-1:0] r_v;
  logic            w_active;
  logic            w_hsync_n;
  logic            w_vsync_n;
  logic [A_W-1:0]  w_rd_addr;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == HC_W'(H_TOTAL - 1)) begin
      r_h <= '0;
      r_v <= (r_v == VC_W'(V_TOTAL - 1)) ? '0 : r_v + VC_W'(1);
    end else begin
      r_h <= r_h + HC_W'(1);
    end
  end

  assign w_active  = (r_h < HC_W'(H_ACTIVE)) && (r_v < VC_W'(V_ACTIVE));
  assign w_hsync_n = !((r_h >= HC_W'(H_ACTIVE + H_FP)) && (r_h < HC_W'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vsync_n = !((r_v >= VC_W'(V_ACTIVE + V_FP)) && (r_v < VC_W'(V_ACTIVE + V_FP + V_SYNC)));
  assign w_rd_addr = w_active ? row_base(A_W'(r_v >> SHIFT)) + A_W'(r_h >> SHIFT) : '0;

  logic [2:0] r_mem [DEPTH];
  logic [2:0] r_rd_data;

  // Simple dual-port RAM, read-before-write on address collision, never reset.
  always_ff @(posedge clk_25) begin
    if (r_wr_en) r_mem[r_wr_addr] <= r_wr_data;
    r_rd_data <= r_mem[w_rd_addr];
  end

  logic r_blank_d;
  logic r_hsync_d;
  logic r_vsync_d;

  // Sync and blank ride alongside the RAM read so all outputs stay aligned.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_blank_d <= 1'b1;
      r_hsync_d <= 1'b1;
      r_vsync_d <= 1'b1;
      vga_rgb   <= 3'b000;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_blank <= 1'b1;
    end else begin
      r_blank_d <= !w_active;
      r_hsync_d <= w_hsync_n;
      r_vsync_d <= w_vsync_n;
      vga_rgb   <= r_blank_d ? 3'b000 : r_rd_data;
      vga_hsync <= r_hsync_d;
      vga_vsync <= r_vsync_d;
      vga_blank <= r_blank_d;
    end
  end

endmodule

// File: tb/tb_vga_pixel_buffer.sv
// Scoreboard bench for vga_pixel_buffer on a scaled-down 32x16 raster.
module tb_vga_pixel_buffer;
  localparam int unsigned H_ACTIVE = 32;
  localparam int unsigned H_FP     = 4;
  localparam int unsigned H_SYNC   = 8;
  localparam int unsigned H_BP     = 4;
  localparam int unsigned V_ACTIVE = 16;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam int unsigned SHIFT    = 2;
  localparam int DEC   = 1 << SHIFT;
  localparam int LW    = H_ACTIVE / DEC;
  localparam int DEPTH = LW * (V_ACTIVE / DEC);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clk;
  logic       reset;
  logic       pix_write;
  logic [2:0] pix_data;
  logic       line_start;
  logic       frame_start;
  logic [2:0] vga_rgb;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_blank;
  logic       frame_done;
  logic       overflow;

  vga_pixel_buffer #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SHIFT(SHIFT)
  ) dut (
    .clk_25(clk), .reset(reset), .pix_write(pix_write), .pix_data(pix_data),
    .line_start(line_start), .frame_start(frame_start), .vga_rgb(vga_rgb),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       bl;
    bit         known;
  } vexp_t;

  typedef struct {
    int   due;
    logic fd;
    logic ov;
  } cexp_t;

  vexp_t vq[$];
  cexp_t cq[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: raster position, camera position and picture memory.
  int         m_cyc = 0;
  int         m_n = 0;
  int         m_x = 0;
  int         m_y = 0;
  bit         m_fl = 0;
  int         m_stored = 0;
  bit         m_ovf = 0;
  bit         m_in_reset = 1;
  logic [2:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  bit         pend_v = 0;
  int         pend_a = 0;
  logic [2:0] pend_d = 3'b000;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", nm, m_cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, m_cyc, act, exp);
    end
  endtask

  int    k, h, v, a;
  bit    act, fd;
  vexp_t ve_m;
  cexp_t ce_m;

  always @(posedge clk) begin
    k = m_cyc;
    m_cyc++;
    if (reset) begin
      if (pend_v) begin
        m_mem[pend_a]   = pend_d;
        m_known[pend_a] = 1'b1;
      end
      pend_v = 0; m_x = 0; m_y = 0; m_fl = 0; m_stored = 0; m_ovf = 0; m_n = 0;
      m_in_reset = 1;
      vq.delete();
      cq.delete();
      ve_m.rgb = 3'b000; ve_m.hs = 1'b1; ve_m.vs = 1'b1; ve_m.bl = 1'b1; ve_m.known = 1'b1;
      ve_m.due = k + 1; vq.push_back(ve_m);
      ve_m.due = k + 2; vq.push_back(ve_m);
      ce_m.due = k + 1; ce_m.fd = 1'b0; ce_m.ov = 1'b0; cq.push_back(ce_m);
    end else begin
      m_in_reset = 0;
      h = m_n % H_TOT;
      v = m_n / H_TOT;
      m_n = (m_n + 1) % FRAME;
      act = (h < H_ACTIVE) && (v < V_ACTIVE);
      a = (v / DEC) * LW + h / DEC;
      ve_m.due   = k + 2;
      ve_m.bl    = !act;
      ve_m.hs    = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
      ve_m.vs    = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
      ve_m.rgb   = act ? m_mem[a] : 3'b000;
      ve_m.known = !act || m_known[a];
      vq.push_back(ve_m);
      if (pend_v) begin
        m_mem[pend_a]   = pend_d;
        m_known[pend_a] = 1'b1;
      end
      pend_v = 0;
      fd = 0;
      if (frame_start) begin
        fd = (m_stored == DEPTH);
        m_x = 0; m_y = 0; m_fl = 1; m_stored = 0;
      end else if (line_start) begin
        m_x = 0;
        if (!m_fl) m_y++;
        m_fl = 0;
      end
      if (pix_write) begin
        if (m_x < H_ACTIVE && m_y < V_ACTIVE) begin
          if (m_x % DEC == 0 && m_y % DEC == 0) begin
            pend_v = 1;
            pend_a = (m_y / DEC) * LW + m_x / DEC;
            pend_d = pix_data;
            if (m_stored < DEPTH) m_stored++;
          end
        end else begin
          m_ovf = 1;
        end
        m_x++;
      end
      ce_m.due = k + 1; ce_m.fd = fd; ce_m.ov = m_ovf;
      cq.push_back(ce_m);
    end
  end

  vexp_t ve;
  cexp_t ce;
  logic  prev_vs = 1'b1;
  int    last_vs_fall = -1;
  int    hs_run = 0;
  int    vs_run = 0;

  // Monitor: pops whatever expectation falls due this cycle, plus sync-shape checks.
  always @(negedge clk) begin
    if (vq.size() > 0 && vq[0].due == m_cyc) begin
      ve = vq.pop_front();
      if (ve.known) chk("rgb", vga_rgb, ve.rgb);
      chk("hsync", {2'b00, vga_hsync}, {2'b00, ve.hs});
      chk("vsync", {2'b00, vga_vsync}, {2'b00, ve.vs});
      chk("blank", {2'b00, vga_blank}, {2'b00, ve.bl});
    end
    if (cq.size() > 0 && cq[0].due == m_cyc) begin
      ce = cq.pop_front();
      chk("frame_done", {2'b00, frame_done}, {2'b00, ce.fd});
      chk("overflow", {2'b00, overflow}, {2'b00, ce.ov});
    end
    if (m_in_reset) begin
      last_vs_fall = -1;
      hs_run = 0;
      vs_run = 0;
    end else begin
      if (prev_vs === 1'b1 && vga_vsync === 1'b0) begin
        if (last_vs_fall >= 0) chk_int("vsync_period", m_cyc - last_vs_fall, FRAME);
        last_vs_fall = m_cyc;
      end
      if (vga_hsync === 1'b0) hs_run++;
      else begin
        if (hs_run > 0) chk_int("hsync_width", hs_run, H_SYNC);
        hs_run = 0;
      end
      if (vga_vsync === 1'b0) vs_run++;
      else begin
        if (vs_run > 0) chk_int("vsync_width", vs_run, V_SYNC * H_TOT);
        vs_run = 0;
      end
    end
    prev_vs = vga_vsync;
  end

  task automatic drive(input logic fs, input logic ls, input logic pw, input logic [2:0] d);
    frame_start = fs;
    line_start  = ls;
    pix_write   = pw;
    pix_data    = d;
    @(negedge clk);
    frame_start = 1'b0;
    line_start  = 1'b0;
    pix_write   = 1'b0;
    pix_data    = 3'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [2:0] pixval(input int mode, input int x, input int y);
    logic [2:0] pal [5];
    pal[0] = 3'b100; pal[1] = 3'b010; pal[2] = 3'b001; pal[3] = 3'b000; pal[4] = 3'b111;
    if (mode == 0) return 3'b100;
    if (mode == 1) return (x == 4 && y == 8) ? 3'b010 : 3'b001;
    return pal[$urandom_range(0, 4)];
  endfunction

  task automatic write_frame(input int mode, input int lines);
    int x0;
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    for (int y = 0; y < lines; y++) begin
      x0 = 0;
      if (mode == 2 && $urandom_range(0, 1) == 1) begin
        drive(1'b0, 1'b1, 1'b1, pixval(mode, 0, y));
        x0 = 1;
      end else begin
        drive(1'b0, 1'b1, 1'b0, 3'b000);
      end
      for (int x = x0; x < H_ACTIVE; x++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b0, 1'b1, pixval(mode, x, y));
      end
    end
    drive(1'b1, 1'b0, 1'b0, 3'b000);
  endtask

  int waited;

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    pix_write = 1'b0;
    pix_data = 3'b000;
    line_start = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2 * FRAME);
    // Whole picture red, then the single-green-block pattern.
    write_frame(0, V_ACTIVE);
    idle(FRAME + 8);
    write_frame(1, V_ACTIVE);
    idle(FRAME + 8);
    // Pixel sharing a cycle with frame_start lands at address 0.
    drive(1'b1, 1'b0, 1'b1, 3'b111);
    idle(FRAME + 8);
    // Truncated frame must not report completion.
    write_frame(2, 10);
    idle(8);
    // One pixel past the end of a line.
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    drive(1'b0, 1'b1, 1'b0, 3'b000);
    for (int x = 0; x <= H_ACTIVE; x++) drive(1'b0, 1'b0, 1'b1, pixval(2, x, 0));
    idle(FRAME / 2);
    for (int f = 0; f < 3; f++) begin
      write_frame(2, V_ACTIVE);
      idle($urandom_range(10, FRAME / 2));
    end
    // Reset in the middle of the active area.
    waited = 0;
    while (!(m_n % H_TOT == 20 && m_n / H_TOT == 10) && waited < 2 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited >= 2 * FRAME) begin
      bad++;
      $display("FAIL reset_point_wait cycle=%0d got=timeout expected=h20_v10", m_cyc);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(FRAME + 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
